// File: rtl/ymux_arb.sv
// ----------------------------------------------------------------------------
// ymux_arb
//   Registered N-channel multiplexer/arbiter. Selects one of CHANNELS
//   valid/ready input streams into a single one-entry output register,
//   either by an external select (mode=0) or by round-robin arbitration
//   (mode=1). One-cycle latency, one word per cycle when out_ready stays high.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_data    CHANNELS*SIZE; channel i at [i*SIZE +: SIZE]
//   in_valid   per-channel valid
//   in_ready   per-channel accept, one-hot or zero (combinational)
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel passed in fixed mode
//   out_data   registered selected data
//   out_chan   channel id of out_data
//   out_valid  output register holds data
//   out_ready  downstream accept
// ----------------------------------------------------------------------------
module ymux_arb #(
  parameter  int SIZE     = 32,
  parameter  int CHANNELS = 4,
  localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNELS*SIZE-1:0] in_data,
  input  logic [CHANNELS-1:0]      in_valid,
  output logic [CHANNELS-1:0]      in_ready,
  input  logic                     mode,
  input  logic [SELW-1:0]          sel,
  output logic [SIZE-1:0]          out_data,
  output logic [SELW-1:0]          out_chan,
  output logic                     out_valid,
  input  logic                     out_ready
);

  // Channel-id addition modulo CHANNELS. Operands are always < CHANNELS,
  // so a single conditional subtract is enough.
  function automatic logic [SELW-1:0] f_chan_add(input logic [SELW-1:0] a,
                                                 input logic [SELW-1:0] b);
    logic [SELW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (SELW+1)'(CHANNELS)) s = s - (SELW+1)'(CHANNELS);
    return s[SELW-1:0];
  endfunction

  logic [SIZE-1:0]       r_data_p1;
  logic [SELW-1:0]       r_chan_p1;
  logic                  r_vld_p1;
  logic [SELW-1:0]       r_ptr;

  logic [2*CHANNELS-1:0] w_rot_dbl;
  logic [CHANNELS-1:0]   w_rot;
  logic                  w_gnt_vld;
  logic [SELW-1:0]       w_gnt;
  logic [SIZE-1:0]       w_gnt_data;
  logic                  w_load_en;
  logic                  w_xfer;

  // Round-robin search runs on in_valid rotated right by the pointer, so
  // bit k of w_rot is channel (ptr+k) mod CHANNELS.
  always_comb begin
    w_rot_dbl = {in_valid, in_valid} >> r_ptr;
    w_rot     = w_rot_dbl[CHANNELS-1:0];
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    if (mode) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (!w_gnt_vld && w_rot[k]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = f_chan_add(r_ptr, SELW'(k));
        end
      end
    end else begin
      // A select value with no matching channel simply never grants.
      for (int c = 0; c < CHANNELS; c++) begin
        if (sel == SELW'(c) && in_valid[c]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = SELW'(c);
        end
      end
    end
  end

  assign w_load_en = !r_vld_p1 || out_ready;
  assign w_xfer    = !reset && w_load_en && w_gnt_vld;

  always_comb begin
    w_gnt_data = '0;
    in_ready   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_gnt == SELW'(c)) begin
        w_gnt_data  = in_data[c*SIZE +: SIZE];
        in_ready[c] = w_xfer;
      end
    end
  end

  // ---- stage p1: output buffer and round-robin pointer ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_chan_p1 <= '0;
      r_ptr     <= '0;
    end else if (w_xfer) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= w_gnt_data;
      r_chan_p1 <= w_gnt;
      if (mode) r_ptr <= f_chan_add(w_gnt, SELW'(1));
    end else if (r_vld_p1 && out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign out_data  = r_data_p1;
  assign out_chan  = r_chan_p1;
  assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_ymux_arb.sv
// ----------------------------------------------------------------------------
// tb_ymux_arb
//   Directed and randomized self-checking bench for ymux_arb (4 x 32-bit).
// ----------------------------------------------------------------------------
module tb_ymux_arb;
  localparam int SIZE = 32;
  localparam int CH   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH*SIZE-1:0] in_data;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic              mode;
  logic [1:0]        sel;
  logic [SIZE-1:0]   out_data;
  logic [1:0]        out_chan;
  logic              out_valid;
  logic              out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state (value the DUT registers hold after the last edge)
  logic            m_valid;
  logic [SIZE-1:0] m_data;
  logic [1:0]      m_chan;
  int              m_ptr;
  logic [33:0]     sb_q[$];

  localparam logic [SIZE-1:0] D0 = 32'h1111_0000;
  localparam logic [SIZE-1:0] D1 = 32'h2222_0001;
  localparam logic [SIZE-1:0] D2 = 32'hDEAD_BEEF;
  localparam logic [SIZE-1:0] D3 = 32'h4444_0003;

  ymux_arb #(.SIZE(SIZE), .CHANNELS(CH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_grant(input logic [3:0] iv, input logic md,
                                     input logic [1:0] sl, input int ptr);
    int c;
    if (!md) return iv[sl] ? int'(sl) : -1;
    for (int k = 0; k < CH; k++) begin
      c = (ptr + k) % CH;
      if (iv[c]) return c;
    end
    return -1;
  endfunction

  task automatic rand_cycle(input logic [3:0] iv, input logic md,
                            input logic [1:0] sl, input logic ordy);
    int          g;
    logic        ld;
    logic [3:0]  erdy;
    logic [33:0] w;
    in_valid  = iv;
    mode      = md;
    sel       = sl;
    out_ready = ordy;
    for (int c = 0; c < CH; c++) in_data[c*SIZE +: SIZE] = $urandom;
    #1;
    ld   = !m_valid || ordy;
    g    = model_grant(iv, md, sl, m_ptr);
    erdy = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("rnd_in_ready", in_ready, erdy);
    chk("rnd_onehot0", $onehot0(in_ready), 1);
    chk("rnd_out_valid", out_valid, m_valid);
    chk("rnd_out_data", out_data, m_data);
    chk("rnd_out_chan", out_chan, m_chan);
    if (out_valid && out_ready) begin
      chk("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        w = sb_q.pop_front();
        chk("sb_word", {out_chan, out_data}, w);
      end
    end
    for (int c = 0; c < CH; c++)
      if (in_valid[c] && in_ready[c]) sb_q.push_back({2'(c), in_data[c*SIZE +: SIZE]});
    if (ld && g >= 0) begin
      m_valid = 1'b1;
      m_data  = in_data[g*SIZE +: SIZE];
      m_chan  = 2'(g);
      if (md) m_ptr = (g + 1) % CH;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    tick();
  endtask

  initial begin
    int exp4[4];
    exp4 = '{1, 3, 1, 3};

    // Reset with all channels requesting
    reset     = 1'b1;
    in_data   = {D3, D2, D1, D0};
    in_valid  = 4'b1111;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 4'b0000);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_chan", out_chan, 0);

    // Fixed select of channel 2
    reset = 1'b0;
    sel   = 2'd2;
    #1;
    chk("fix_in_ready_pre", in_ready, 4'b0100);
    tick();
    chk("fix_out_valid", out_valid, 1);
    chk("fix_out_data", out_data, D2);
    chk("fix_out_chan", out_chan, 2);
    chk("fix_in_ready", in_ready, 4'b0100);
    tick();
    chk("fix_in_ready2", in_ready, 4'b0100);
    chk("fix_out_chan2", out_chan, 2);

    // Fixed select of a channel that is not valid: no grant, buffer drains
    sel      = 2'd1;
    in_valid = 4'b1101;
    #1;
    chk("fix_nogrant_rdy", in_ready, 4'b0000);
    tick();
    chk("fix_nogrant_valid", out_valid, 0);
    chk("fix_nogrant_chan_hold", out_chan, 2);
    chk("fix_nogrant_data_hold", out_data, D2);

    // Round-robin, all valid: 0,1,2,3,0
    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_out_chan", out_chan, i % 4);
      chk("rr_out_valid", out_valid, 1);
      chk("rr_out_data", out_data, in_data[(i % 4)*SIZE +: SIZE]);
    end

    // RR skip from ptr=0 with channels 1 and 3 valid
    reset    = 1'b1;
    in_valid = 4'b0000;
    tick();
    reset    = 1'b0;
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("skip_out_chan", out_chan, exp4[i]);
      chk("skip_out_valid", out_valid, 1);
    end
    in_valid = 4'b0000;
    tick();
    chk("skip_drain_valid", out_valid, 0);
    chk("skip_drain_chan", out_chan, 3);
    chk("skip_drain_data", out_data, D3);

    // Backpressure: ptr=0, load ch0 then stall three cycles
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #1;
    chk("bp_rdy_load", in_ready, 4'b0001);
    tick();
    chk("bp_load_chan", out_chan, 0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin mode = 1'b0; sel = 2'd3; end
      if (i == 2) mode = 1'b1;
      #1;
      chk("bp_stall_rdy", in_ready, 4'b0000);
      tick();
      chk("bp_stall_valid", out_valid, 1);
      chk("bp_stall_chan", out_chan, 0);
      chk("bp_stall_data", out_data, D0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", in_ready, 4'b0010);
    tick();
    chk("bp_release_chan", out_chan, 1);
    chk("bp_release_data", out_data, D1);

    // Reset while a word is buffered and a handshake is offered
    reset = 1'b1;
    #1;
    chk("midrst_rdy", in_ready, 4'b0000);
    tick();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_chan", out_chan, 0);
    reset = 1'b0;
    #1;
    chk("midrst_ptr_rdy", in_ready, 4'b0001);

    // Randomized traffic against the reference model and scoreboard
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = '0;
    m_ptr   = 0;
    sb_q.delete();
    for (int i = 0; i < 1000; i++)
      rand_cycle(4'($urandom), 1'($urandom), 2'($urandom), ($urandom % 4) != 0);
    rand_cycle(4'b0000, 1'b1, 2'd0, 1'b1);
    rand_cycle(4'b0000, 1'b1, 2'd0, 1'b1);
    chk("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
